// File: rtl/fetch_queue.sv
// Fetch queue: circular buffer of fetch groups between the IFU and decode.
// Define FETCH_QUEUE_BYPASS_EN to pass a group straight through an empty queue.
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 1
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif

module fq_entry #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         we,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)  q <= '0;
      else if (we) q <= d;
   end
endmodule

module fetch_queue #(
   parameter int FETCH_WIDTH = `FETCH_WIDTH,
   parameter int ADDR_WIDTH  = `INST_ADDR_WIDTH,
   parameter int DEPTH       = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   input  logic [32*FETCH_WIDTH-1:0]  in_instr,
   input  logic [ADDR_WIDTH-1:0]      in_pc,
   input  logic [ADDR_WIDTH-1:0]      in_pc_plus_4,
   output logic                       stall,
   input  logic                       flush,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [32*FETCH_WIDTH-1:0]  out_instr,
   output logic [ADDR_WIDTH-1:0]      out_pc,
   output logic [ADDR_WIDTH-1:0]      out_pc_plus_4,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int IW = 32 * FETCH_WIDTH;
   localparam int EW = IW + 2 * ADDR_WIDTH;

   typedef struct packed {
      logic [IW-1:0]         instr;
      logic [ADDR_WIDTH-1:0] pc;
      logic [ADDR_WIDTH-1:0] pc_plus_4;
   } grp_t;

   grp_t            in_grp, head;
   grp_t            mem [DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   cnt;
   logic            byp, full, push, pop;

   assign in_grp = '{instr: in_instr, pc: in_pc, pc_plus_4: in_pc_plus_4};

`ifdef FETCH_QUEUE_BYPASS_EN
   assign byp = (cnt == '0) && in_valid && !flush;
`else
   assign byp = 1'b0;
`endif

   // pop only counts stored groups, so stall never depends on in_valid/in_*
   assign full  = (cnt == CW'(DEPTH));
   assign pop   = (cnt != '0) && out_ready;
   assign stall = full && !pop;
   assign push  = in_valid && !stall && !flush && !(byp && out_ready);

   for (genvar i = 0; i < DEPTH; i++) begin : g_ent
      fq_entry #(.W(EW)) u_ent (
         .clk   (clk),
         .reset (reset),
         .we    (push && (wr_ptr == PW'(i))),
         .d     (in_grp),
         .q     (mem[i])
      );
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         cnt <= cnt + CW'(push) - CW'(pop);
      end
   end

   assign head          = byp ? in_grp : mem[rd_ptr];
   assign out_valid     = (cnt != '0) || byp;
   assign out_instr     = head.instr;
   assign out_pc        = head.pc;
   assign out_pc_plus_4 = head.pc_plus_4;
   assign count         = cnt;
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed test-plan steps then random traffic,
// each cycle compared against a queue-based reference model.
module tb_fetch_queue;
   localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pcp4;
   } grp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_instr = '0, in_pc = '0, in_pc_plus_4 = '0;
   logic        stall, flush = 1'b0;
   logic        out_valid, out_ready = 1'b0;
   logic [31:0] out_instr, out_pc, out_pc_plus_4;
   logic [2:0]  count;

   int   n_vec = 0;
   int   n_err = 0;
   grp_t q[$];

   fetch_queue #(.FETCH_WIDTH(1), .ADDR_WIDTH(32), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr),
      .in_pc(in_pc), .in_pc_plus_4(in_pc_plus_4), .stall(stall), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_pc(out_pc), .out_pc_plus_4(out_pc_plus_4), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, check outputs before the edge, advance the model.
   task automatic step(input bit v, input logic [31:0] pc, input bit rdy, input bit fl);
      grp_t cur, hd;
      bit   byp_m, stall_m, enq, deq;
      @(negedge clk);
      cur = '{instr: $urandom, pc: pc, pcp4: pc + 32'd4};
      in_valid = v; in_instr = cur.instr; in_pc = cur.pc; in_pc_plus_4 = cur.pcp4;
      out_ready = rdy; flush = fl;
      #1;
      byp_m   = BYP && (q.size() == 0) && v && !fl;
      stall_m = (q.size() == DEPTH) && !rdy;
      chk("count", 32'(count), 32'(q.size()));
      chk("stall", 32'(stall), 32'(stall_m));
      chk("out_valid", 32'(out_valid), 32'((q.size() != 0) || byp_m));
      if ((q.size() != 0) || byp_m) begin
         hd = byp_m ? cur : q[0];
         chk("out_pc", out_pc, hd.pc);
         chk("out_pc_plus_4", out_pc_plus_4, hd.pcp4);
         chk("out_instr", out_instr, hd.instr);
      end
      enq = v && !stall_m && !fl && !(byp_m && rdy);
      deq = (q.size() != 0) && rdy;
      if (fl) q.delete();
      else begin
         if (deq) void'(q.pop_front());
         if (enq) q.push_back(cur);
      end
   endtask

   initial begin
      // reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_out_pc", out_pc, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      step(0, 0, 0, 0);

      // fill, then a dropped fifth group
      for (int i = 0; i < 4; i++) step(1, 32'(4 * i), 0, 0);
      step(1, 32'd16, 0, 0);
      // full and draining: pc 16 accepted while pc 0 leaves
      step(1, 32'd16, 1, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 1, 0);

      // flush with concurrent enq/deq at count 3
      for (int i = 0; i < 3; i++) step(1, 32'(100 + 4 * i), 0, 0);
      step(1, 32'd200, 1, 1);
      step(1, 32'd20, 0, 0);
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);

      // asynchronous reset at count 2
      step(1, 32'd28, 0, 0);
      step(1, 32'd32, 0, 0);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      reset = 1'b0;
      #1;
      chk("async_rst_count", 32'(count), 32'd0);
      chk("async_rst_out_valid", 32'(out_valid), 32'd0);
      q.delete();
      @(negedge clk);
      reset = 1'b1;

      // bypass candidate on an empty queue
      step(1, 32'd24, 1, 0);
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);

      // random traffic
      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 3) != 0), $urandom & 32'hffff_fffc,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
      step(0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

- Decoupling FIFO between the IFU and the decode stage.
- Captures each fetch group presented by the IFU: FETCH_WIDTH instruction words plus the group's pc and pc_plus_4.
- Returns one group per cycle to decode over a valid/ready handshake.
- Drives the IFU's stall input, freezing the pc while no space is available.
- A flush from the redirect path (taken SB, UJ, JALR) discards all buffered groups.

## Interface

Parameters:
- FETCH_WIDTH, default `FETCH_WIDTH: instruction words per fetch group.
- ADDR_WIDTH, default `INST_ADDR_WIDTH: width of pc and pc_plus_4.
- DEPTH, default 4: number of group entries; power of two, at least 2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  IFU presents a fetch group this cycle.
- in_instr  input  32*FETCH_WIDTH  instruction words; word i at bits [32*i+31:32*i].
- in_pc  input  ADDR_WIDTH  pc of the group.
- in_pc_plus_4  input  ADDR_WIDTH  pc_plus_4 of the group.
- stall  output  1  to the IFU stall input; the IFU holds pc while this is high.
- flush  input  1  redirect; discard all contents.
- out_valid  output  1  head group available to decode.
- out_ready  input  1  decode accepts the head group.
- out_instr  output  32*FETCH_WIDTH  head group instruction words.
- out_pc  output  ADDR_WIDTH  head group pc.
- out_pc_plus_4  output  ADDR_WIDTH  head group pc_plus_4.
- count  output  $clog2(DEPTH)+1  number of occupied entries, 0..DEPTH.

## Operation

Storage and pointers:
- Circular buffer of DEPTH entries.
- Write pointer wr_ptr and read pointer rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
- Separate occupancy counter count.

Events:
- Dequeue fire: deq = out_valid && out_ready.
- Stall: stall = (count == DEPTH) && !deq.
  - Combinational, so a full queue being drained this cycle still accepts a group.
- Enqueue fire: enq = in_valid && !stall && !flush.
- On enq: write entry[wr_ptr]; wr_ptr += 1.
- On deq (without flush): rd_ptr += 1.
- Count update: count += enq - deq. Simultaneous enq and deq leave count unchanged, at any occupancy including full and empty.

Outputs:
- out_valid = (count != 0).
- out_* = entry[rd_ptr] (combinational read).
- While out_valid is high, out_* hold stable until deq.

Flush:
- On flush: wr_ptr, rd_ptr and count go to 0 at the next edge.
- Same-cycle enq and deq are ignored.
- Entry contents are not cleared.
- Flush has priority over every other event.
- stall is unaffected by flush in that cycle; it follows count.

Error and idle cases:
- in_valid while stall is high: group dropped. The IFU re-presents it because the pc is held.
- out_ready with count == 0: no effect.

Reset (reset low, asynchronous):
- wr_ptr = 0, rd_ptr = 0, count = 0.
- Therefore out_valid = 0 and stall = 0.
- out_instr, out_pc and out_pc_plus_4 read 0: entries are reset to 0.
- Reset mid-operation discards all contents immediately.

## Timing

- Enqueue-to-output latency: 1 cycle. A group written at edge N is visible on out_* after edge N when the queue was empty.
- stall is combinational from count and out_ready; it has no registered delay.
- A full queue with out_ready held high sustains 1 group/cycle in and out.
- flush at edge N: out_valid = 0 after edge N. The first post-flush group, enqueued at edge N+1, appears after edge N+1.
- No combinational path from in_valid or in_* to stall.

## Configuration

Macro FETCH_QUEUE_BYPASS_EN.

With the macro defined:
- When count == 0 and in_valid && !flush, out_valid = 1 and out_* = in_* in the same cycle (zero latency).
- If out_ready is also high, the group passes through without being written and count stays 0.
- If out_ready is low, the group is enqueued normally.

Without the macro:
- No bypass path; latency is 1 cycle as described under Timing.

## Test plan

All scenarios use DEPTH=4, FETCH_WIDTH=1.

- Reset, then idle: count=0, out_valid=0, stall=0, out_pc=0.
- Fill: enqueue pc 0,4,8,12 with out_ready=0 → count=4, stall=1. A fifth group at pc 16 is dropped, count stays 4, out_pc=0.
- Full and draining: out_ready=1 with in_valid=1 on pc 16 → stall=0, pc 16 enqueued, count stays 4. Dequeue order is 0,4,8,12,16, with pointer wrap verified.
- Flush with enq and deq in the same cycle at count=3 → count=0 and out_valid=0 next cycle; the next group, pc 20, emerges first.
- Reset asserted asynchronously mid-stream at count=2 → count=0 and out_valid=0 before the next clk edge.
- Bypass: empty queue, in_valid with pc 24, out_ready=1.
  - FETCH_QUEUE_BYPASS_EN defined: out_valid=1, out_pc=24 in the same cycle, count stays 0.
  - FETCH_QUEUE_BYPASS_EN undefined: out_valid is asserted one cycle later.
